// File: rtl/logic_analyzer_event_encoder.sv
// logic_analyzer_event_encoder: turns bus changes into timestamped 64-bit records and buffers them in a FWFT FIFO.
// Slots: 0 start, 1 wrap, 2 trigger, 3 pp, 4 data, 5 gate, 6 aux (index order is emit priority).
module logic_analyzer_event_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [31:0] data_in,
  input  logic [31:0] gate_data_in,
  input  logic [31:0] aux_data_in,
  input  logic [31:0] trigger_data_in,
  input  logic pp_active,
  output logic [63:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NS = 7;
  localparam logic [4*NS-1:0] TYPES = {4'd3, 4'd2, 4'd1, 4'd7, 4'd4, 4'd5, 4'd8};
  logic en_d, rise, live, hit, push, pop, lost_grant;
  logic [TS_WIDTH-1:0] ts, ts_n;
  logic [TS_WIDTH-1:0] sts [NS];
  logic [31:0] sval [NS];
  logic [31:0] nval [NS];
  logic [31:0] prev_data, prev_gate, prev_aux, lost_cnt, lost_next;
  logic prev_pp;
  logic [NS-1:0] pend, set, gvec, lost_now;
  logic [2:0] sel;
  logic [32:0] lost_sum;
  logic [63:0] rec, head;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [AW:0] count, count_n;
  assign rise = enable && !en_d;
  assign live = enable && en_d;
  assign ts_n = enable ? (en_d ? ts + TS_WIDTH'(1) : '0) : ts;
  assign set = {live && aux_data_in != prev_aux, live && gate_data_in != prev_gate,
                live && data_in != prev_data, live && pp_active != prev_pp,
                live && trigger_data_in != '0, live && ts == '1, rise};
  always_comb begin
    nval[0] = data_in;
    nval[1] = '0;
    nval[2] = trigger_data_in;
    nval[3] = {31'd0, pp_active};
    nval[4] = data_in;
    nval[5] = gate_data_in;
    nval[6] = aux_data_in;
    hit = 1'b0;
    sel = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (pend[i]) begin
        hit = 1'b1;
        sel = 3'(i);
      end
    push = count != (AW+1)'(FIFO_DEPTH) && (hit || lost_cnt != '0);
    lost_grant = push && !hit;
    gvec = (push && hit) ? NS'(1) << sel : '0;
    rec = hit ? {TYPES[{sel, 2'b00} +: 4], sts[sel], sval[sel]} : {4'd6, ts, lost_cnt};
  end
  // A slot granted on the same edge it is re-set is re-armed, not lost; start never counts
  assign lost_now = set & pend & ~gvec & 7'b1111110;
  assign lost_sum = {1'b0, lost_grant ? 32'd0 : lost_cnt} + 33'($countones(lost_now));
  assign lost_next = lost_sum[32] ? '1 : lost_sum[31:0];
  assign pop = count != '0 && out_ready;
  assign rd_n = rd + AW'(pop);
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign head = (push && rd_n == wr) ? rec : mem[rd_n];
  assign out_valid = count != '0;
  assign fifo_count = count;
  always_ff @(posedge clk)
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NS; i++) begin
        sval[i] <= '0;
        sts[i] <= '0;
      end
    end else
      for (int i = 0; i < NS; i++)
        if (set[i]) begin
          pend[i] <= 1'b1;
          sval[i] <= nval[i];
          sts[i] <= ts_n;
        end else if (gvec[i]) pend[i] <= 1'b0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= rec;
  always_ff @(posedge clk)
    if (rst) begin
      en_d <= 1'b0;
      ts <= '0;
      prev_data <= '0;
      prev_gate <= '0;
      prev_aux <= '0;
      prev_pp <= 1'b0;
      lost_cnt <= '0;
      overflow <= 1'b0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      out_data <= '0;
    end else begin
      en_d <= enable;
      ts <= ts_n;
      if (enable) begin
        prev_data <= data_in;
        prev_gate <= gate_data_in;
        prev_aux <= aux_data_in;
        prev_pp <= pp_active;
      end
      lost_cnt <= rise ? '0 : lost_next;
      overflow <= !rise && (overflow || lost_now != '0);
      rd <= rd_n;
      wr <= wr + AW'(push);
      count <= count_n;
      if (count_n != '0) out_data <= head;
    end
endmodule

// File: tb/tb_logic_analyzer_event_encoder.sv
// tb_logic_analyzer_event_encoder: directed scenarios plus random stimulus against a record-queue reference model.
module tb_logic_analyzer_event_encoder;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, enable = 0, pp_active = 0, out_ready = 0;
  logic [31:0] data_in = 0, gate_data_in = 0, aux_data_in = 0, trigger_data_in = 0;
  logic [63:0] out_data;
  logic out_valid, overflow;
  logic [4:0] fifo_count;
  int total = 0, bad = 0;
  logic [63:0] q [$];
  logic [63:0] m_last;
  bit m_pend [7];
  logic [31:0] m_val [7];
  logic [27:0] m_tsv [7];
  logic [3:0] ty [7] = '{4'd8, 4'd5, 4'd4, 4'd7, 4'd1, 4'd2, 4'd3};
  logic [27:0] m_ts;
  logic [31:0] m_lost, p_data, p_gate, p_aux;
  bit m_ovf, m_en_d, p_pp;

  logic_analyzer_event_encoder #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(28)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .gate_data_in(gate_data_in),
    .aux_data_in(aux_data_in), .trigger_data_in(trigger_data_in), .pp_active(pp_active),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int g, losses;
    bit rise, live, have;
    bit ev [7];
    logic [31:0] nv [7];
    logic [27:0] nts;
    logic [63:0] r;
    longint sum;
    if (rst) begin
      q.delete();
      m_last = 0;
      m_ts = 0;
      m_lost = 0;
      m_ovf = 0;
      m_en_d = 0;
      {p_data, p_gate, p_aux, p_pp} = '0;
      for (int i = 0; i < 7; i++) begin
        m_pend[i] = 0;
        m_val[i] = 0;
        m_tsv[i] = 0;
      end
      return;
    end
    g = -1;
    have = 0;
    r = 0;
    if (q.size() < DEPTH) begin
      for (int i = 6; i >= 0; i--) if (m_pend[i]) g = i;
      if (g >= 0) begin
        r = {ty[g], m_tsv[g], m_val[g]};
        have = 1;
      end else if (m_lost != 0) begin
        r = {4'd6, m_ts, m_lost};
        have = 1;
        g = 7;
      end
    end
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (have) q.push_back(r);
    if (q.size() > 0) m_last = q[0];
    rise = enable && !m_en_d;
    live = enable && m_en_d;
    nts = rise ? 28'd0 : enable ? m_ts + 28'd1 : m_ts;
    ev[0] = rise;                      nv[0] = data_in;
    ev[1] = live && m_ts == 28'hFFFFFFF; nv[1] = 0;
    ev[2] = live && trigger_data_in != 0; nv[2] = trigger_data_in;
    ev[3] = live && pp_active != p_pp;  nv[3] = {31'd0, pp_active};
    ev[4] = live && data_in != p_data;  nv[4] = data_in;
    ev[5] = live && gate_data_in != p_gate; nv[5] = gate_data_in;
    ev[6] = live && aux_data_in != p_aux;   nv[6] = aux_data_in;
    if (g == 7) m_lost = 0;
    if (g >= 0 && g < 7) m_pend[g] = 0;
    losses = 0;
    for (int i = 0; i < 7; i++)
      if (ev[i]) begin
        if (m_pend[i]) losses++;
        m_pend[i] = 1;
        m_val[i] = nv[i];
        m_tsv[i] = nts;
      end
    sum = longint'(m_lost) + losses;
    m_lost = sum > 64'hFFFFFFFF ? 32'hFFFFFFFF : sum[31:0];
    if (losses != 0) m_ovf = 1;
    if (rise) begin
      m_lost = 0;
      m_ovf = 0;
    end
    if (enable) {p_data, p_gate, p_aux, p_pp} = {data_in, gate_data_in, aux_data_in, pp_active};
    m_ts = nts;
    m_en_d = enable;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 64'(out_valid), 64'(q.size() > 0));
    chk("data", out_data, m_last);
    chk("count", 64'(fifo_count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    ticks(2);
    rst = 0;
    chk("rst_data", out_data, 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    enable = 1;
    data_in = 3;
    tick();
    chk("start_lat", 64'(out_valid), 64'd0);
    tick();
    chk("start_rec", out_data, {4'd8, 28'd0, 32'd3});
    ticks(3);
    chk("start_only", 64'(fifo_count), 64'd1);
    out_ready = 1;
    ticks(5);
    chk("idle_empty", 64'(out_valid), 64'd0);
    data_in = 7;
    tick();
    chk("data_lat", 64'(out_valid), 64'd0);
    data_in = 7;
    tick();
    chk("data_type", 64'(out_data[63:60]), 64'd1);
    chk("data_pay", 64'(out_data[31:0]), 64'd7);
    ticks(3);
    out_ready = 0;
    data_in = 42;
    aux_data_in = 15;
    trigger_data_in = 7;
    pp_active = 1;
    tick();
    trigger_data_in = 0;
    ticks(6);
    chk("multi_cnt", 64'(fifo_count), 64'd4);
    chk("multi_head", 64'(out_data[63:60]), 64'd4);
    out_ready = 1;
    ticks(6);
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = data_in ^ 32'h1;
      tick();
    end
    tick();
    chk("fill_cnt", 64'(fifo_count), 64'(DEPTH));
    chk("fill_ovf", 64'(overflow), 64'd1);
    out_ready = 1;
    ticks(25);
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_lost", 64'(out_data[63:60]), 64'd6);
    out_ready = 0;
    @(negedge clk);
    force dut.ts = 28'hFFFFFFC;
    #1 release dut.ts;
    m_ts = 28'hFFFFFFC;
    ticks(4);
    data_in = 99;
    ticks(3);
    chk("wrap_rec", out_data, {4'd5, 28'd0, 32'd0});
    chk("wrap_cnt", 64'(fifo_count), 64'd2);
    out_ready = 1;
    ticks(4);
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      data_in = data_in + 1;
      tick();
    end
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_cnt", 64'(fifo_count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(3) == 0) data_in = $urandom_range(7);
      if ($urandom_range(7) == 0) gate_data_in = $urandom;
      if ($urandom_range(7) == 0) aux_data_in = $urandom_range(3);
      trigger_data_in = ($urandom_range(7) == 0) ? $urandom : 32'd0;
      if ($urandom_range(7) == 0) pp_active = ~pp_active;
      out_ready = $urandom_range(9) < 6;
      rst = $urandom_range(499) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
